// File: rtl/atomrvcore_ifu.sv
// ---------------------------------------------------------------------------
// atomrvcore_ifu -- instruction fetch unit
//
// Holds the program counter and fetches one instruction word at a time from
// instruction memory, with at most one request in flight. Returned words are
// buffered together with their fetch address in a small FIFO and handed to
// the decode stage over a valid/ready handshake. Branches, JAL and JALR from
// decode redirect the PC and flush every wrong-path word, including one that
// is still in flight.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_ni         asynchronous active-low reset
//   pc_rst_ni      synchronous PC reset: behaves as a redirect to RESET_PC
//   IR_EN_i        fetch enable; low stops new requests only
//   BE_i           taken conditional branch redirect
//   UJE_i          JAL redirect
//   JALRE_i        JALR redirect (highest priority of the three)
//   immed_i        sign-extended immediate from decode
//   branch_pc_i    PC of the redirecting instruction (BE/JAL base)
//   operand_A_i    rs1 value (JALR base)
//   imem_req_o     one-cycle fetch request strobe
//   imem_addr_o    word-aligned fetch address
//   imem_rvalid_i  fetch response valid
//   imem_rdata_i   fetch response word
//   instr_valid_o  instr_o/pc_o hold a buffered instruction
//   instr_ready_i  decode takes the instruction this cycle
//   instr_o        instruction at the head of the buffer (NOP when empty)
//   pc_o           fetch address of instr_o
// ---------------------------------------------------------------------------
module atomrvcore_ifu #(
  parameter int unsigned          DATAWIDTH  = 32,
  parameter logic [DATAWIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned          FIFO_DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 pc_rst_ni,
  input  logic                 IR_EN_i,
  input  logic                 BE_i,
  input  logic                 UJE_i,
  input  logic                 JALRE_i,
  input  logic [DATAWIDTH-1:0] immed_i,
  input  logic [DATAWIDTH-1:0] branch_pc_i,
  input  logic [DATAWIDTH-1:0] operand_A_i,
  output logic                 imem_req_o,
  output logic [DATAWIDTH-1:0] imem_addr_o,
  input  logic                 imem_rvalid_i,
  input  logic [DATAWIDTH-1:0] imem_rdata_i,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  output logic [DATAWIDTH-1:0] instr_o,
  output logic [DATAWIDTH-1:0] pc_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [DATAWIDTH-1:0] NOP_INSTR  = DATAWIDTH'(32'h0000_0013);
  localparam logic [DATAWIDTH-1:0] PC_STEP    = DATAWIDTH'(4);
  localparam logic [DATAWIDTH-1:0] JALR_MASK  = {{(DATAWIDTH-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0]     FIFO_LIMIT = CNT_W'(FIFO_DEPTH);

  // IDLE    : nothing in flight, waiting for enable and buffer space
  // REQ     : request strobe cycle
  // WAIT    : request in flight, its word will be kept
  // DISCARD : request in flight, its word belongs to a flushed path
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DISCARD
  } state_e;

  state_e state_q, state_d;

  logic [DATAWIDTH-1:0] pc_q, pc_d;
  logic [DATAWIDTH-1:0] fetch_pc_q;

  logic [DATAWIDTH-1:0] fifo_instr_q [FIFO_DEPTH];
  logic [DATAWIDTH-1:0] fifo_pc_q    [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q, count_after;

  logic                 flush;
  logic [DATAWIDTH-1:0] target;
  logic                 push, pop;
  logic                 space_after;
  logic                 in_flight;

  // A pc_rst_ni pulse is just a redirect to RESET_PC that beats every other
  // redirect source; among the decode redirects JALR beats JAL beats branch.
  // JAL and branch share the same target formula, so they share a branch.
  always_comb begin
    target = RESET_PC;
    if (!pc_rst_ni) begin
      target = RESET_PC;
    end else if (JALRE_i) begin
      target = (operand_A_i + immed_i) & JALR_MASK;
    end else if (UJE_i || BE_i) begin
      target = branch_pc_i + {immed_i[DATAWIDTH-2:0], 1'b0};
    end
  end

  assign flush = !pc_rst_ni || JALRE_i || UJE_i || BE_i;

  // Only a word answering a request made on the current path is buffered.
  // A word that lands in a redirect cycle is dropped with the rest of the
  // flushed path. Occupancy after this cycle's push/pop decides whether a
  // new request may reserve a slot, which is what keeps the FIFO from ever
  // overflowing.
  always_comb begin
    push        = imem_rvalid_i && (state_q == ST_WAIT) && !flush;
    pop         = instr_valid_o && instr_ready_i && !flush;
    count_after = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    space_after = (count_after < FIFO_LIMIT);
  end

  // Next-state and request logic. The normal path walks IDLE/REQ/WAIT; a
  // redirect overrides it. On a redirect we must remember whether memory
  // still owes us a word: a REQ cycle has just issued one, and WAIT/DISCARD
  // still owe one unless it arrives in this very cycle. An owed word sends
  // us to DISCARD so it is swallowed before the target is fetched.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    imem_req_o = 1'b0;
    in_flight  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (IR_EN_i && space_after) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        imem_req_o = 1'b1;
        pc_d       = pc_q + PC_STEP;
        state_d    = ST_WAIT;
        in_flight  = 1'b1;
      end
      ST_WAIT, ST_DISCARD: begin
        in_flight = !imem_rvalid_i;
        if (imem_rvalid_i) begin
          state_d = (IR_EN_i && space_after) ? ST_REQ : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (flush) begin
      pc_d = target;
      if (in_flight) begin
        state_d = ST_DISCARD;
      end else begin
        state_d = IR_EN_i ? ST_REQ : ST_IDLE;
      end
    end
  end

  // Fetches are always word aligned; a target with bit 1 set simply reads
  // the word containing it.
  assign imem_addr_o = {pc_q[DATAWIDTH-1:2], 2'b00};

  // State, PC and the address of the request in flight. The in-flight
  // address is kept separately because pc_q has already moved on by the
  // time the word comes back.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == ST_REQ) begin
        fetch_pc_q <= imem_addr_o;
      end
    end
  end

  // Buffer bookkeeping. A flush empties the buffer in the same cycle, so
  // decode sees instr_valid_o drop on the following cycle. Pointers wrap
  // naturally because the depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_after;
    end
  end

  // Buffer storage needs no reset: an entry is only ever read after it has
  // been written, because validity comes from count_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
      fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  // The head entry goes straight to decode. An empty buffer shows a NOP so
  // that decode never sees stale data even if it ignores instr_valid_o.
  always_comb begin
    instr_valid_o = (count_q != '0);
    instr_o       = NOP_INSTR;
    pc_o          = RESET_PC;
    if (instr_valid_o) begin
      instr_o = fifo_instr_q[rd_ptr_q];
      pc_o    = fifo_pc_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_atomrvcore_ifu.sv
// ---------------------------------------------------------------------------
// tb_atomrvcore_ifu -- bench for the instruction fetch unit
//
// A memory responder answers every request after a programmable latency.
// A reference model keeps the stream of instructions decode should see as a
// queue: words are appended when memory answers a request made on the
// current path, removed when decode accepts them, and the queue is cleared
// on any redirect or reset. Directed scenarios then pin request addresses
// and delivered words to hand-computed values.
// ---------------------------------------------------------------------------
module tb_atomrvcore_ifu;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          BOUND     = 40;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        pc_rst_ni;
  logic        IR_EN_i;
  logic        BE_i;
  logic        UJE_i;
  logic        JALRE_i;
  logic [31:0] immed_i;
  logic [31:0] branch_pc_i;
  logic [31:0] operand_A_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  int n_compared = 0;
  int n_failed   = 0;
  int mem_latency = 1;

  // reference model state
  logic [31:0] model_pc;
  logic [63:0] model_q [$];
  int          epoch   = 0;
  int          req_tag = -1;
  logic [31:0] last_req_addr;
  logic [31:0] req_log [$];
  logic [31:0] pop_pc_log [$];
  logic [31:0] pop_instr_log [$];

  atomrvcore_ifu dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .pc_rst_ni     (pc_rst_ni),
    .IR_EN_i       (IR_EN_i),
    .BE_i          (BE_i),
    .UJE_i         (UJE_i),
    .JALRE_i       (JALRE_i),
    .immed_i       (immed_i),
    .branch_pc_i   (branch_pc_i),
    .operand_A_i   (operand_A_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory contents: address 0 holds addi x1,x0,5; other words are tagged
  // with their address so misplaced words are obvious.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h0050_0093 ^ (addr << 8);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle's worth of decode-side inputs just after the rising edge.
  task automatic applyStimulus(input logic ir_en, input logic ready,
                               input logic pc_rst_n, input logic be,
                               input logic uje, input logic jalre,
                               input logic [31:0] imm, input logic [31:0] bpc,
                               input logic [31:0] opa);
    @(posedge clk_i);
    #1;
    IR_EN_i       = ir_en;
    instr_ready_i = ready;
    pc_rst_ni     = pc_rst_n;
    BE_i          = be;
    UJE_i         = uje;
    JALRE_i       = jalre;
    immed_i       = imm;
    branch_pc_i   = bpc;
    operand_A_i   = opa;
  endtask

  task automatic runNormal();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic settle();
    @(negedge clk_i);
    #1;
  endtask

  task automatic waitReqs(input int n, input string name);
    int i = 0;
    while (req_log.size() < n && i < BOUND) begin
      settle();
      i++;
    end
    if (req_log.size() < n) checkOutput({name, "_req_timeout"}, 32'(req_log.size()), 32'(n));
  endtask

  task automatic waitPops(input int n, input string name);
    int i = 0;
    while (pop_pc_log.size() < n && i < BOUND) begin
      settle();
      i++;
    end
    if (pop_pc_log.size() < n) checkOutput({name, "_pop_timeout"}, 32'(pop_pc_log.size()), 32'(n));
  endtask

  // Memory responder: one outstanding request, answered mem_latency cycles
  // after the request cycle, for exactly one cycle.
  initial begin : memory_model
    bit          pend = 1'b0;
    int          cnt  = 0;
    logic [31:0] paddr = '0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(negedge clk_i);
      if (imem_req_o === 1'b1) begin
        pend  = 1'b1;
        paddr = imem_addr_o;
        cnt   = mem_latency;
      end
      @(posedge clk_i);
      #1;
      imem_rvalid_i = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mem_word(paddr);
          pend          = 1'b0;
        end
      end
    end
  end

  // Compare process: every cycle, check the outputs against the model, then
  // advance the model with this cycle's inputs.
  initial begin : compare_proc
    logic [31:0] tgt;
    model_pc = 32'h0;
    forever begin
      @(negedge clk_i);
      if (rst_ni !== 1'b1) begin
        checkOutput("reset_req", 32'(imem_req_o), 32'h0);
        checkOutput("reset_addr", imem_addr_o, 32'h0);
        checkOutput("reset_valid", 32'(instr_valid_o), 32'h0);
        checkOutput("reset_instr", instr_o, NOP_INSTR);
        checkOutput("reset_pc", pc_o, 32'h0);
        model_q.delete();
        epoch++;
        req_tag  = -1;
        model_pc = 32'h0;
      end else begin
        checkOutput("valid", 32'(instr_valid_o), 32'(model_q.size() != 0));
        if (model_q.size() != 0) begin
          checkOutput("instr", instr_o, model_q[0][31:0]);
          checkOutput("pc", pc_o, model_q[0][63:32]);
        end else begin
          checkOutput("empty_instr", instr_o, NOP_INSTR);
        end
        if (imem_req_o === 1'b1) begin
          checkOutput("req_addr", imem_addr_o, model_pc & 32'hFFFF_FFFC);
          checkOutput("req_space", 32'(model_q.size() < 2), 32'h1);
          req_tag       = epoch;
          last_req_addr = imem_addr_o;
          req_log.push_back(imem_addr_o);
          model_pc      = model_pc + 32'd4;
        end
        if (!pc_rst_ni || JALRE_i || UJE_i || BE_i) begin
          if (!pc_rst_ni)   tgt = 32'h0;
          else if (JALRE_i) tgt = (operand_A_i + immed_i) & 32'hFFFF_FFFE;
          else              tgt = branch_pc_i + (immed_i << 1);
          model_q.delete();
          epoch++;
          model_pc = tgt;
        end else begin
          if (instr_valid_o && instr_ready_i && model_q.size() != 0) begin
            pop_pc_log.push_back(model_q[0][63:32]);
            pop_instr_log.push_back(model_q[0][31:0]);
            void'(model_q.pop_front());
          end
          if (imem_rvalid_i && req_tag == epoch) begin
            model_q.push_back({last_req_addr, imem_rdata_i});
            req_tag = -1;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int n0;
    int p0;
    rst_ni        = 1'b0;
    pc_rst_ni     = 1'b1;
    IR_EN_i       = 1'b0;
    instr_ready_i = 1'b1;
    BE_i          = 1'b0;
    UJE_i         = 1'b0;
    JALRE_i       = 1'b0;
    immed_i       = '0;
    branch_pc_i   = '0;
    operand_A_i   = '0;

    // reset state
    repeat (3) @(posedge clk_i);
    settle();
    checkOutput("rst_valid", 32'(instr_valid_o), 32'h0);
    checkOutput("rst_instr", instr_o, NOP_INSTR);
    checkOutput("rst_addr", imem_addr_o, 32'h0);

    // boot: sequential fetch from RESET_PC at latency 1
    $display("[TB] boot fetch");
    @(posedge clk_i);
    #1;
    rst_ni  = 1'b1;
    IR_EN_i = 1'b1;
    waitReqs(3, "boot");
    checkOutput("boot_req0", req_log[0], 32'h0);
    checkOutput("boot_req1", req_log[1], 32'h4);
    checkOutput("boot_req2", req_log[2], 32'h8);
    waitPops(1, "boot");
    checkOutput("boot_pc0", pop_pc_log[0], 32'h0);
    checkOutput("boot_instr0", pop_instr_log[0], 32'h0050_0093);

    // decode stalls: buffer fills, fetching stops, then drains in order
    $display("[TB] decode stall");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (6) settle();
    n0 = req_log.size();
    repeat (4) settle();
    checkOutput("stall_no_req", 32'(req_log.size() - n0), 32'h0);
    checkOutput("stall_valid", 32'(instr_valid_o), 32'h1);
    p0 = pop_pc_log.size();
    runNormal();
    waitPops(p0 + 2, "drain");
    checkOutput("drain_order", pop_pc_log[p0 + 1], pop_pc_log[p0] + 32'd4);

    // JAL: 0x10 + (0x8 << 1) = 0x20
    $display("[TB] jal redirect");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8, 32'h10, 32'h0);
    settle();
    n0 = req_log.size();
    runNormal();
    settle();
    checkOutput("jal_flush_valid", 32'(instr_valid_o), 32'h0);
    waitReqs(n0 + 1, "jal");
    checkOutput("jal_target", req_log[n0], 32'h20);

    // JALR and branch together: JALR wins, (0x101 + 4) & ~1 = 0x104
    $display("[TB] jalr priority");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4, 32'h40, 32'h101);
    settle();
    n0 = req_log.size();
    runNormal();
    waitReqs(n0 + 2, "jalr");
    checkOutput("jalr_target", req_log[n0], 32'h104);
    checkOutput("jalr_next", req_log[n0 + 1], 32'h108);

    // misaligned JAL target 0x30 + 2 = 0x32 fetches word 0x30
    $display("[TB] misaligned target");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1, 32'h30, 32'h0);
    settle();
    n0 = req_log.size();
    runNormal();
    waitReqs(n0 + 2, "misal");
    checkOutput("misal_target", req_log[n0], 32'h30);
    checkOutput("misal_next", req_log[n0 + 1], 32'h34);

    // pc_rst_ni overrides a simultaneous JAL
    $display("[TB] pc reset");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h80, 32'h0);
    settle();
    n0 = req_log.size();
    runNormal();
    waitReqs(n0 + 1, "pcrst");
    checkOutput("pcrst_target", req_log[n0], 32'h0);

    // redirect while a latency-3 response is outstanding: 0x200 + 0x20
    $display("[TB] redirect in wait");
    mem_latency = 3;
    n0 = req_log.size();
    waitReqs(n0 + 1, "pre_wait");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h200, 32'h0);
    settle();
    n0 = req_log.size();
    p0 = pop_pc_log.size();
    runNormal();
    for (int i = 0; i < 3; i++) begin
      settle();
      checkOutput("discard_valid", 32'(instr_valid_o), 32'h0);
    end
    waitReqs(n0 + 1, "discard");
    checkOutput("discard_target", req_log[n0], 32'h220);
    waitPops(p0 + 1, "discard");
    checkOutput("discard_pc", pop_pc_log[p0], 32'h220);
    checkOutput("discard_instr", pop_instr_log[p0], mem_word(32'h220));

    // rst_ni mid-WAIT; the stale response arrives while idle
    $display("[TB] reset mid wait");
    n0 = req_log.size();
    waitReqs(n0 + 1, "pre_rst");
    @(posedge clk_i);
    #1;
    rst_ni  = 1'b0;
    IR_EN_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    n0 = req_log.size();
    p0 = pop_pc_log.size();
    for (int i = 0; i < 4; i++) begin
      settle();
      checkOutput("stale_valid", 32'(instr_valid_o), 32'h0);
    end
    checkOutput("stale_no_req", 32'(req_log.size() - n0), 32'h0);
    mem_latency = 1;
    runNormal();
    waitReqs(n0 + 1, "rst");
    checkOutput("rst_first_req", req_log[n0], 32'h0);
    waitPops(p0 + 1, "rst");
    checkOutput("rst_first_pc", pop_pc_log[p0], 32'h0);
    checkOutput("rst_first_instr", pop_instr_log[p0], 32'h0050_0093);

    repeat (4) settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
